mem_bank_arbiter: RTL and testbench
===================================

Name: mem_bank_arbiter

Overview:
- Shares one single-byte memory bank port among NUM_REQ requesters using round-robin arbitration.
- Sequences burst transfers into single-byte bank accesses with address auto-increment.
- The bank port follows the team's memBank handshake: a one-cycle request pulse, then the bank raises busy, drops busy when the access completes, then spends one idle (READY) cycle.
- Sits between the cache/fetch requesters and a memBank instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 30, bank address width
- DATA_W, 8, bank data word width
- BURST_BITS, 2, burst length field width; a value of L means L+1 beats
- TIMEOUT, 64, max cycles allowed in WAIT_BUSY or WAIT_DONE before aborting

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held until req_done
- req_wr  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  start address; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  write data for the current beat
- req_burst  in  NUM_REQ*BURST_BITS  burst length field
- req_grant  out  NUM_REQ  one-hot; held for the whole transaction
- beat_ack  out  NUM_REQ  one-cycle pulse per completed beat
- req_done  out  NUM_REQ  one-cycle pulse on the last beat, coincident with its beat_ack
- rsp_data  out  DATA_W  read data; valid when beat_ack is high on a read
- err  out  1  one-cycle pulse on timeout abort
- bank_req  out  1  one-cycle request pulse to the bank
- bank_wr  out  1  write enable to the bank
- bank_addr  out  ADDR_W  bank address
- bank_wdata  out  DATA_W  bank write data
- bank_busy  in  1  bank busy
- bank_rdata  in  DATA_W  bank read data

Behaviour:
- Reset (async): state=IDLE; all outputs 0; rr pointer=NUM_REQ-1, so requester 0 has first priority. Reset mid-burst abandons the transfer with no done/ack pulse.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If any req_valid is set, grant the first set index searching from ptr+1 modulo NUM_REQ.
  - Latch wr, addr and beat count (burst+1) for that requester; set req_grant; go to ISSUE.
  - Arbitration happens only in IDLE.
- ISSUE:
  - bank_req=1 for exactly this cycle.
  - bank_wr, bank_addr and bank_wdata (sampled from the granted requester's req_wdata) are driven now.
  - These values are held stable until the beat completes. Go to WAIT_BUSY.
- WAIT_BUSY: when bank_busy is sampled 1, go to WAIT_DONE.
- WAIT_DONE: when bank_busy is sampled 0, the beat is complete:
  - Register rsp_data=bank_rdata (reads only; on writes rsp_data holds its previous value).
  - Pulse beat_ack[g] in the next cycle.
  - Decrement the beat count; increment the address modulo 2^ADDR_W (wraps 0x3FFFFFFF -> 0).
  - Go to GAP.
- GAP:
  - One cycle, matching the bank's READY cycle; beat_ack[g] is high in this cycle.
  - If beats remain, go to ISSUE; the requester must present the next wdata in this cycle.
  - Otherwise pulse req_done[g] in the same cycle, set ptr=g, clear req_grant next cycle and go to IDLE.
- Minimum beat time: 4 cycles (ISSUE, WAIT_BUSY, WAIT_DONE, GAP) with a zero-latency bank.
- Timeout:
  - A counter runs in WAIT_BUSY/WAIT_DONE.
  - When it reaches TIMEOUT: pulse err, pulse req_done[g] with no beat_ack, set ptr=g, go to IDLE.
  - The counter resets on every state entry.
- Boundary cases:
  - req_valid dropped mid-transaction: ignored; the burst runs to completion.
  - Only one requester active: it is re-granted back-to-back, with one IDLE cycle between transactions.
  - A requester whose req_valid is still high in the cycle req_done is pulsed is treated as a new request.
  - req_addr/req_burst changes after grant are ignored.

Test Plan:
- Single read, req0 addr=0x10 burst=0, bank rdata=0xA5, bank latency 2 -> one bank_req with bank_addr=0x10, bank_wr=0; beat_ack[0] and req_done[0] pulse together; rsp_data=0xA5.
- Write burst, req2 addr=0x3FFFFFFE burst=3, wdata 0x11,0x22,0x33,0x44 -> bank addresses 0x3FFFFFFE, 0x3FFFFFFF, 0x0, 0x1 with matching data; 4 beat_acks; req_done[2] only on the 4th.
- All four requesters assert together from reset, each burst=0 -> grants in order 0,1,2,3; then, with all still requesting, grant wraps to 0; req_grant is always one-hot.
- Bank never asserts busy, TIMEOUT=64 -> err and req_done[g] pulse 64 cycles after ISSUE; no beat_ack; next requester is granted.
- Reset asserted during WAIT_DONE of a 4-beat read -> all outputs 0 immediately; after release, req1 and req0 both pending -> req0 is granted first.
- Requester deasserts req_valid after grant, burst=1 -> both beats still issued; req_done is pulsed.

Source files
------------

// File: rtl/mem_bank_arbiter_if.sv
// rtl/mem_bank_arbiter_if.sv - requester and memBank signal bundle for the bank arbiter
interface mem_bank_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 8,
  parameter int BURST_BITS = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_W-1:0]     req_addr;
  logic [NUM_REQ*DATA_W-1:0]     req_wdata;
  logic [NUM_REQ*BURST_BITS-1:0] req_burst;
  logic [NUM_REQ-1:0]            req_grant;
  logic [NUM_REQ-1:0]            beat_ack;
  logic [NUM_REQ-1:0]            req_done;
  logic [DATA_W-1:0]             rsp_data;
  logic                          err;
  logic                          bank_req;
  logic                          bank_wr;
  logic [ADDR_W-1:0]             bank_addr;
  logic [DATA_W-1:0]             bank_wdata;
  logic                          bank_busy;
  logic [DATA_W-1:0]             bank_rdata;

  // Arbiter side: consumes requests and bank status, drives grants and the bank port.
  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_burst, bank_busy, bank_rdata,
    output req_grant, beat_ack, req_done, rsp_data, err,
    output bank_req, bank_wr, bank_addr, bank_wdata
  );

  // Requester/bank side.
  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_burst, bank_busy, bank_rdata,
    input  req_grant, beat_ack, req_done, rsp_data, err,
    input  bank_req, bank_wr, bank_addr, bank_wdata
  );
endinterface

// File: rtl/mem_bank_arbiter.sv
// rtl/mem_bank_arbiter.sv - round-robin burst arbiter in front of a single-byte memBank port
module mem_bank_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 8,
  parameter int BURST_BITS = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_bank_arbiter_if.master bus
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = BURST_BITS + 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      ptr, gidx, pick, cand;
  logic                  pick_ok;
  logic [NUM_REQ-1:0]    grant;
  logic                  wr_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q, rsp_q;
  logic [BEAT_W-1:0]     beats_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  timed_out;
  logic                  bank_req_c, err_c;
  logic [NUM_REQ-1:0]    beat_ack_c, req_done_c;

  logic [ADDR_W-1:0]     addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]     wdata_arr [NUM_REQ];
  logic [BURST_BITS-1:0] burst_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    assign burst_arr[i] = bus.req_burst[i*BURST_BITS +: BURST_BITS];
  end

  assign timed_out = ((state == WAIT_BUSY) || (state == WAIT_DONE)) && (cnt_q == CNT_W'(TIMEOUT));

  // Round-robin pick: the first requester after ptr wins; scanning far-to-near lets the nearest overwrite.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and the single-cycle pulse outputs.
  always_comb begin
    state_nxt  = state;
    bank_req_c = 1'b0;
    err_c      = 1'b0;
    beat_ack_c = '0;
    req_done_c = '0;
    case (state)
      IDLE: if (pick_ok) state_nxt = ISSUE;
      ISSUE: begin
        bank_req_c = 1'b1;
        state_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (timed_out) begin
          err_c      = 1'b1;
          req_done_c = grant;
          state_nxt  = IDLE;
        end else if (bus.bank_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (timed_out) begin
          err_c      = 1'b1;
          req_done_c = grant;
          state_nxt  = IDLE;
        end else if (!bus.bank_busy) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        beat_ack_c = grant;
        if (beats_q == '0) begin
          req_done_c = grant;
          state_nxt  = IDLE;
        end else begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction datapath: latch on grant, advance per beat, release grant on done or abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= IDX_W'(NUM_REQ - 1);
      gidx    <= '0;
      grant   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ok) begin
            gidx    <= pick;
            grant   <= NUM_REQ'(1) << pick;
            wr_q    <= bus.req_wr[pick];
            addr_q  <= addr_arr[pick];
            wdata_q <= wdata_arr[pick];
            beats_q <= BEAT_W'(burst_arr[pick]) + BEAT_W'(1);
          end
        end
        ISSUE: cnt_q <= CNT_W'(1);
        WAIT_BUSY: begin
          if (timed_out) begin
            grant <= '0;
            ptr   <= gidx;
          end else if (bus.bank_busy) begin
            cnt_q <= CNT_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (timed_out) begin
            grant <= '0;
            ptr   <= gidx;
          end else if (!bus.bank_busy) begin
            if (!wr_q) rsp_q <= bus.bank_rdata;
            beats_q <= beats_q - BEAT_W'(1);
            addr_q  <= addr_q + ADDR_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (beats_q == '0) begin
            grant <= '0;
            ptr   <= gidx;
          end else begin
            wdata_q <= wdata_arr[gidx];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_grant  = grant;
  assign bus.beat_ack   = beat_ack_c;
  assign bus.req_done   = req_done_c;
  assign bus.rsp_data   = rsp_q;
  assign bus.err        = err_c;
  assign bus.bank_req   = bank_req_c;
  assign bus.bank_wr    = wr_q;
  assign bus.bank_addr  = addr_q;
  assign bus.bank_wdata = wdata_q;
endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb/tb_mem_bank_arbiter.sv - scoreboard bench for mem_bank_arbiter
module tb_mem_bank_arbiter;
  localparam int N = 4, AW = 30, DW = 8, BB = 2, TO = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bank_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_BITS(BB)) bus();

  mem_bank_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_BITS(BB), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
    logic        dead;
  } bank_t;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] done;
    logic       err;
    logic       chk;
    logic [7:0] data;
  } rsp_t;

  bank_t exp_bank[$];
  rsp_t  exp_rsp[$];
  int    exp_grant[$];
  logic [7:0] wd_q[$];
  int    wd_who = 0;

  int checks = 0, errors = 0, cyc = 0, issue_cyc = 0;
  int txn_left[4];

  logic [3:0]  t_valid, t_wr;
  logic [29:0] t_addr[4];
  logic [7:0]  t_wdata[4];
  logic [1:0]  t_burst[4];

  assign bus.req_valid = t_valid;
  assign bus.req_wr    = t_wr;
  assign bus.req_addr  = {t_addr[3], t_addr[2], t_addr[1], t_addr[0]};
  assign bus.req_wdata = {t_wdata[3], t_wdata[2], t_wdata[1], t_wdata[0]};
  assign bus.req_burst = {t_burst[3], t_burst[2], t_burst[1], t_burst[0]};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void pb(logic wr, logic [29:0] a, logic [7:0] wd, logic [7:0] rd, int lat, logic dead);
    exp_bank.push_back('{wr, a, wd, rd, lat, dead});
  endfunction

  function automatic void pr(logic [3:0] ack, logic [3:0] done, logic e, logic c, logic [7:0] d);
    exp_rsp.push_back('{ack, done, e, c, d});
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [29:0] a, input logic [1:0] b,
                         input logic [7:0] wd, input int n);
    t_wr[i] = wr;
    t_addr[i] = a;
    t_burst[i] = b;
    t_wdata[i] = wd;
    txn_left[i] = n;
    t_valid[i] = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 64'(bus.req_grant), 0);
    chk({tag, "_ack"}, 64'(bus.beat_ack), 0);
    chk({tag, "_done"}, 64'(bus.req_done), 0);
    chk({tag, "_err"}, 64'(bus.err), 0);
    chk({tag, "_bank_req"}, 64'(bus.bank_req), 0);
    chk({tag, "_bank_wr"}, 64'(bus.bank_wr), 0);
    chk({tag, "_bank_addr"}, 64'(bus.bank_addr), 0);
    chk({tag, "_bank_wdata"}, 64'(bus.bank_wdata), 0);
    chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_bank.size() != 0 || exp_grant.size() != 0 || t_valid != 0)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completes"}, 64'(n >= 2000), 0);
    repeat (3) @(negedge clk);
  endtask

  // Bank model: checks every request against the expected access list and plays back busy/rdata.
  initial begin
    bank_t b;
    bus.bank_busy = 1'b0;
    bus.bank_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.bank_req) begin
        issue_cyc = cyc;
        if (exp_bank.size() == 0) begin
          chk("bank_unexpected_req", 64'(bus.bank_addr), 64'hFFFF_FFFF);
        end else begin
          b = exp_bank.pop_front();
          chk("bank_wr", 64'(bus.bank_wr), 64'(b.wr));
          chk("bank_addr", 64'(bus.bank_addr), 64'(b.addr));
          if (b.wr) chk("bank_wdata", 64'(bus.bank_wdata), 64'(b.wdata));
          if (!b.dead) begin
            bus.bank_busy = 1'b1;
            for (int k = 0; k < b.lat + 1 && !reset; k++) @(negedge clk);
            bus.bank_busy = 1'b0;
            bus.bank_rdata = b.rdata;
          end
        end
      end
    end
  end

  // Requester behaviour: drop req_valid after the last wanted transaction, feed next write beat on ack.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.req_done[i] && txn_left[i] > 0) begin
            txn_left[i]--;
            if (txn_left[i] == 0) t_valid[i] = 1'b0;
          end
          if (bus.beat_ack[i] && i == wd_who && wd_q.size() > 0) t_wdata[i] = wd_q.pop_front();
        end
      end
    end
  end

  // Monitor: grant order/one-hot and response events are popped from the scoreboard queues.
  initial begin
    logic [3:0] prev_grant;
    rsp_t e;
    int g;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_grant = '0;
      end else begin
        if (bus.req_grant != 0) begin
          chk("grant_onehot", 64'($onehot(bus.req_grant)), 1);
          if (bus.req_grant != prev_grant) begin
            if (exp_grant.size() == 0) chk("grant_unexpected", 64'(bus.req_grant), 0);
            else begin
              g = exp_grant.pop_front();
              chk("grant_order", 64'(bus.req_grant), 64'(1 << g));
            end
          end
        end
        prev_grant = bus.req_grant;
        if (bus.beat_ack != 0 || bus.req_done != 0 || bus.err) begin
          if (exp_rsp.size() == 0) begin
            chk("rsp_unexpected", {bus.beat_ack, bus.req_done, 7'd0, bus.err}, 0);
          end else begin
            e = exp_rsp.pop_front();
            chk("beat_ack", 64'(bus.beat_ack), 64'(e.ack));
            chk("req_done", 64'(bus.req_done), 64'(e.done));
            chk("err", 64'(bus.err), 64'(e.err));
            if (e.chk) chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            if (e.err) chk("timeout_cycles", 64'(cyc - issue_cyc), 64'(TO));
          end
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    t_valid = '0;
    t_wr = '0;
    for (int i = 0; i < 4; i++) begin
      t_addr[i] = '0;
      t_wdata[i] = '0;
      t_burst[i] = '0;
      txn_left[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single read from requester 0, bank latency 2.
    pb(1'b0, 30'h10, 8'h00, 8'hA5, 2, 1'b0);
    pr(4'b0001, 4'b0001, 1'b0, 1'b1, 8'hA5);
    exp_grant.push_back(0);
    set_req(0, 1'b0, 30'h10, 2'd0, 8'h00, 1);
    wait_idle("single_read");

    // Four-beat write burst across the address wrap; rsp_data keeps the last read value.
    wd_who = 2;
    wd_q = '{8'h22, 8'h33, 8'h44};
    pb(1'b1, 30'h3FFFFFFE, 8'h11, 8'h00, 1, 1'b0);
    pb(1'b1, 30'h3FFFFFFF, 8'h22, 8'h00, 1, 1'b0);
    pb(1'b1, 30'h00000000, 8'h33, 8'h00, 1, 1'b0);
    pb(1'b1, 30'h00000001, 8'h44, 8'h00, 1, 1'b0);
    pr(4'b0100, 4'b0000, 1'b0, 1'b1, 8'hA5);
    pr(4'b0100, 4'b0000, 1'b0, 1'b1, 8'hA5);
    pr(4'b0100, 4'b0000, 1'b0, 1'b1, 8'hA5);
    pr(4'b0100, 4'b0100, 1'b0, 1'b1, 8'hA5);
    exp_grant.push_back(2);
    set_req(2, 1'b1, 30'h3FFFFFFE, 2'd3, 8'h11, 1);
    wait_idle("write_burst");

    // All four requesters from reset, two transactions each: 0,1,2,3 then wrap to 0.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pb(1'b0, 30'(32'h100 + k % 4), 8'h00, 8'(32'h30 + k), 1, 1'b0);
      pr(4'(1 << (k % 4)), 4'(1 << (k % 4)), 1'b0, 1'b1, 8'(32'h30 + k));
      exp_grant.push_back(k % 4);
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 30'(32'h100 + i), 2'd0, 8'h00, 2);
    wait_idle("round_robin");

    // Bank never raises busy for requester 1: abort after TIMEOUT, then requester 3 proceeds.
    pb(1'b1, 30'h123, 8'h9E, 8'h00, 1, 1'b1);
    pr(4'b0000, 4'b0010, 1'b1, 1'b0, 8'h00);
    pb(1'b0, 30'h2, 8'h00, 8'h5C, 1, 1'b0);
    pr(4'b1000, 4'b1000, 1'b0, 1'b1, 8'h5C);
    exp_grant.push_back(1);
    exp_grant.push_back(3);
    set_req(1, 1'b1, 30'h123, 2'd0, 8'h9E, 1);
    set_req(3, 1'b0, 30'h2, 2'd0, 8'h00, 1);
    wait_idle("timeout");

    // Reset during WAIT_DONE of a 4-beat read; afterwards requester 0 beats requester 1.
    pb(1'b0, 30'h200, 8'h00, 8'h00, 10, 1'b0);
    exp_grant.push_back(3);
    set_req(3, 1'b0, 30'h200, 2'd3, 8'h00, 1);
    n = 0;
    while (!bus.bank_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midreset_issue_seen", 64'(n >= 200), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    t_valid = '0;
    for (int i = 0; i < 4; i++) txn_left[i] = 0;
    pb(1'b0, 30'h40, 8'h00, 8'h61, 1, 1'b0);
    pr(4'b0001, 4'b0001, 1'b0, 1'b1, 8'h61);
    pb(1'b0, 30'h41, 8'h00, 8'h62, 2, 1'b0);
    pr(4'b0010, 4'b0010, 1'b0, 1'b1, 8'h62);
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    set_req(1, 1'b0, 30'h41, 2'd0, 8'h00, 1);
    set_req(0, 1'b0, 30'h40, 2'd0, 8'h00, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_idle("after_reset");

    // req_valid, addr and burst change after grant: the 2-beat burst still completes.
    pb(1'b0, 30'h80, 8'h00, 8'h71, 1, 1'b0);
    pb(1'b0, 30'h81, 8'h00, 8'h72, 1, 1'b0);
    pr(4'b0100, 4'b0000, 1'b0, 1'b1, 8'h71);
    pr(4'b0100, 4'b0100, 1'b0, 1'b1, 8'h72);
    exp_grant.push_back(2);
    set_req(2, 1'b0, 30'h80, 2'd1, 8'h00, 1);
    n = 0;
    while (!bus.req_grant[2] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drop_grant_seen", 64'(n >= 200), 0);
    t_valid[2] = 1'b0;
    t_addr[2] = 30'h999;
    t_burst[2] = 2'd0;
    wait_idle("valid_drop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
